shift_pipe: RTL and testbench

Parametrised, pipelined shift/rotate unit that replaces the single-width combinational barrel shifter on the execute path. It supports logical left, logical right, arithmetic right and rotate right at any power-of-two width. Pipeline registers can be placed between shift stages, and a valid/ready elastic handshake on both sides lets it stall behind a busy consumer without losing or reordering operations. A user tag travels with each operation so results can be matched to their issuing slot.

---
 rtl/shift_pipe.sv | 98 +++++++++
 tb/tb_shift_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: elastic pipelined SLL/SRL/SRA/ROR unit; in_valid/in_ready/in_data/in_shamt/in_op/in_tag accept ops, out_valid/out_ready/out_data/out_tag return results in order
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter logic [$clog2(WIDTH)-2:0] REG_MASK = 4'b0010,
  parameter int TAG_W = 4,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [LOG2W-1:0] RM = {1'b1, REG_MASK};
  logic [LOG2W-1:0]            qv, ld;
  logic [LOG2W-1:0][WIDTH-1:0] qd, sh;
  logic [LOG2W-1:0][TAG_W-1:0] qt;
  logic [LOG2W-2:0][LOG2W-1:0] qs;
  logic [LOG2W-2:0][1:0]       qo;
  logic [LOG2W-2:0]            qg;
  logic [LOG2W:0][WIDTH-1:0]   d;
  logic [LOG2W:0][TAG_W-1:0]   t;
  logic [LOG2W:0]              v, r;
  logic [LOG2W-1:0][LOG2W-1:0] s;
  logic [LOG2W-1:0][1:0]       o;
  logic [LOG2W-1:0]            g;
  function automatic logic [WIDTH-1:0] stage(input logic [WIDTH-1:0] x, input logic en,
                                             input logic [1:0] op, input logic sg, input int a);
    logic [WIDTH-1:0] sr;
    sr = x >> a;
    return !en ? x :
           op == 2'b00 ? x << a :
           op == 2'b01 ? sr :
           op == 2'b10 ? sr | (sg ? ~({WIDTH{1'b1}} >> a) : '0) :
                         sr | (x << (WIDTH - a));
  endfunction
  always_comb begin
    d[0] = in_data;
    t[0] = in_tag;
    v[0] = in_valid;
    s[0] = in_shamt;
    o[0] = in_op;
    g[0] = in_data[WIDTH-1];
    for (int j = 0; j < LOG2W; j++) begin
      sh[j]  = stage(d[j], s[j][LOG2W-1-j], o[j], g[j], 1 << (LOG2W-1-j));
      d[j+1] = RM[j] ? qd[j] : sh[j];
      t[j+1] = RM[j] ? qt[j] : t[j];
      v[j+1] = RM[j] ? qv[j] : v[j];
    end
    for (int j = 0; j < LOG2W-1; j++) begin
      s[j+1] = RM[j] ? qs[j] : s[j];
      o[j+1] = RM[j] ? qo[j] : o[j];
      g[j+1] = RM[j] ? qg[j] : g[j];
    end
  end
  always_comb begin
    r[LOG2W] = out_ready;
    for (int j = LOG2W-1; j >= 0; j--) begin
      ld[j] = !qv[j] || r[j+1];
      r[j]  = RM[j] ? ld[j] : r[j+1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      qv <= '0;
      qd <= '0;
      qt <= '0;
      qs <= '0;
      qo <= '0;
      qg <= '0;
    end else begin
      for (int j = 0; j < LOG2W; j++)
        if (RM[j] && ld[j]) begin
          qv[j] <= v[j];
          if (v[j]) begin
            qd[j] <= sh[j];
            qt[j] <= t[j];
          end
        end
      for (int j = 0; j < LOG2W-1; j++)
        if (RM[j] && ld[j] && v[j]) begin
          qs[j] <= s[j];
          qo[j] <= o[j];
          qg[j] <= g[j];
        end
    end
  assign in_ready  = r[0];
  assign out_valid = v[LOG2W];
  assign out_data  = d[LOG2W];
  assign out_tag   = t[LOG2W];
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and random checks of two shift_pipe configurations against a queue-based reference
module tb_shift_pipe;
  localparam int LA = 2, LB = 3;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic av = 0, ar = 1, a_in_ready, a_out_valid;
  logic [31:0] ad = 0, a_out_data;
  logic [4:0] ash = 0;
  logic [1:0] aop = 0;
  logic [3:0] atag = 0, a_out_tag;
  logic bv = 0, br = 1, b_in_ready, b_out_valid;
  logic [7:0] bd = 0, b_out_data;
  logic [2:0] bsh = 0;
  logic [1:0] bop = 0;
  logic [3:0] btag = 0, b_out_tag;
  shift_pipe ua (.clk(clk), .rst(rst), .in_valid(av), .in_ready(a_in_ready), .in_data(ad),
                 .in_shamt(ash), .in_op(aop), .in_tag(atag), .out_valid(a_out_valid),
                 .out_ready(ar), .out_data(a_out_data), .out_tag(a_out_tag));
  shift_pipe #(.WIDTH(8), .REG_MASK(2'b11), .TAG_W(4)) ub (
                 .clk(clk), .rst(rst), .in_valid(bv), .in_ready(b_in_ready), .in_data(bd),
                 .in_shamt(bsh), .in_op(bop), .in_tag(btag), .out_valid(b_out_valid),
                 .out_ready(br), .out_data(b_out_data), .out_tag(b_out_tag));
  int n_cmp = 0, n_err = 0, cy = 0, na_out = 0, nb_in = 0, k = 0, s0 = 0;
  bit lat_on = 0, aexp_on = 0, bexp_on = 0;
  logic [63:0] aexp = 0, bexp = 0;
  logic afi, afo, bfi, bfo;
  logic [63:0] qa_d[$], qb_d[$];
  logic [3:0] qa_t[$], qb_t[$];
  int qa_c[$], qb_c[$];
  function automatic logic [63:0] ref_op(input logic [63:0] x, input int sh, input logic [1:0] op, input int w);
    logic [63:0] m, sx;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = x & m;
    sx = x[w-1] ? (x | ~m) : x;
    case (op)
      2'd0: return (x << sh) & m;
      2'd1: return x >> sh;
      2'd2: return 64'($signed(sx) >>> sh) & m;
      default: return ((x >> sh) | (x << (w - sh))) & m;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [63:0] ob, input logic [63:0] ex);
    n_cmp++;
    assert (ob === ex) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", nm, ob, ex);
    end
  endtask
  task automatic cyc();
    #2;
    afi = av && a_in_ready;
    afo = a_out_valid && ar;
    bfi = bv && b_in_ready;
    bfo = b_out_valid && br;
    chk("a_in_ready", a_in_ready, !(qa_d.size() == LA && !ar));
    chk("b_in_ready", b_in_ready, !(qb_d.size() == LB && !br));
    if (qa_d.size() == 0) chk("a_idle", a_out_valid, 0);
    if (qb_d.size() == 0) chk("b_idle", b_out_valid, 0);
    if (a_out_valid && qa_d.size() > 0) begin
      chk("a_data", a_out_data, qa_d[0]);
      chk("a_tag", a_out_tag, qa_t[0]);
      if (lat_on && afo) chk("a_latency", cy - qa_c[0], LA);
    end
    if (b_out_valid && qb_d.size() > 0) begin
      chk("b_data", b_out_data, qb_d[0]);
      chk("b_tag", b_out_tag, qb_t[0]);
      if (lat_on && bfo) chk("b_latency", cy - qb_c[0], LB);
    end
    if (afo && qa_d.size() > 0) begin
      void'(qa_d.pop_front()); void'(qa_t.pop_front()); void'(qa_c.pop_front());
      na_out++;
    end
    if (bfo && qb_d.size() > 0) begin
      void'(qb_d.pop_front()); void'(qb_t.pop_front()); void'(qb_c.pop_front());
    end
    if (afi) begin
      qa_d.push_back(aexp_on ? aexp : ref_op(64'(ad), int'(ash), aop, 32));
      qa_t.push_back(atag);
      qa_c.push_back(cy);
    end
    if (bfi) begin
      qb_d.push_back(bexp_on ? bexp : ref_op(64'(bd), int'(bsh), bop, 8));
      qb_t.push_back(btag);
      qb_c.push_back(cy);
      nb_in++;
    end
    @(posedge clk);
    #1;
    cy++;
  endtask
  task automatic put_a(input logic [31:0] x, input logic [4:0] sh, input logic [1:0] op,
                       input logic [3:0] tg, input logic [31:0] ex);
    av = 1; ad = x; ash = sh; aop = op; atag = tg; aexp_on = 1; aexp = 64'(ex);
    cyc();
    av = 0; aexp_on = 0;
  endtask
  task automatic put_b(input logic [7:0] x, input logic [2:0] sh, input logic [1:0] op,
                       input logic [3:0] tg, input logic [7:0] ex);
    bv = 1; bd = x; bsh = sh; bop = op; btag = tg; bexp_on = 1; bexp = 64'(ex);
    cyc();
    bv = 0; bexp_on = 0;
  endtask
  task automatic drain();
    av = 0; bv = 0; ar = 1; br = 1;
    for (int i = 0; i < 30 && (qa_d.size() != 0 || qb_d.size() != 0); i++) cyc();
    chk("drain_a", qa_d.size(), 0);
    chk("drain_b", qb_d.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_tag", a_out_tag, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_data", b_out_data, 0);
    rst = 0;
    #1;
    chk("rst_a_ready", a_in_ready, 1);
    chk("rst_b_ready", b_in_ready, 1);
    lat_on = 1;
    put_a(32'h0000_0001, 5'd31, 2'd0, 4'd3, 32'h8000_0000);
    drain();
    put_a(32'h8000_0000, 5'd4, 2'd2, 4'd1, 32'hF800_0000);
    put_a(32'h8000_0000, 5'd4, 2'd1, 4'd2, 32'h0800_0000);
    put_a(32'h7000_0000, 5'd4, 2'd2, 4'd4, 32'h0700_0000);
    put_a(32'h0000_00F1, 5'd4, 2'd3, 4'd5, 32'h1000_000F);
    for (int i = 0; i < 4; i++) put_a(32'hDEAD_BEEF, 5'd0, 2'(i), 4'(6 + i), 32'hDEAD_BEEF);
    drain();
    lat_on = 0;
    s0 = na_out;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      av = k < 8; ad = $urandom(); ash = 5'($urandom_range(0, 31)); aop = 2'($urandom_range(0, 3));
      atag = 4'(k); ar = !(c >= 3 && c < 7);
      if (c == 5) begin
        #1;
        chk("a_bp_stall_ready", a_in_ready, 0);
      end
      cyc();
      if (afi) k++;
    end
    drain();
    chk("a_bp_count", na_out - s0, 8);
    for (int i = 0; i < 150; i++) begin
      av = $urandom_range(0, 3) != 0; ad = $urandom(); ash = 5'($urandom_range(0, 31));
      aop = 2'($urandom_range(0, 3)); atag = 4'($urandom()); ar = $urandom_range(0, 3) != 0;
      cyc();
    end
    drain();
    ar = 0; av = 1; aop = 2'd0;
    ad = 32'h1234_5678; ash = 5'd3; atag = 4'd9;
    cyc();
    ad = 32'h0F0F_0F0F; ash = 5'd1; atag = 4'd10;
    cyc();
    av = 0;
    cyc();
    chk("a_pre_rst_valid", a_out_valid, 1);
    rst = 1;
    #1;
    chk("a_mid_rst_valid", a_out_valid, 0);
    chk("a_mid_rst_data", a_out_data, 0);
    chk("a_mid_rst_tag", a_out_tag, 0);
    qa_d.delete(); qa_t.delete(); qa_c.delete();
    @(posedge clk);
    #1;
    rst = 0;
    ar = 1;
    #1;
    chk("a_post_rst_ready", a_in_ready, 1);
    chk("a_post_rst_valid", a_out_valid, 0);
    lat_on = 1;
    put_a(32'h0000_0F00, 5'd8, 2'd1, 4'd11, 32'h0000_000F);
    drain();
    put_b(8'h81, 3'd1, 2'd3, 4'd1, 8'hC0);
    put_b(8'h90, 3'd7, 2'd2, 4'd2, 8'hFF);
    drain();
    s0 = nb_in;
    bv = 1; br = 1;
    for (int i = 0; i < 20; i++) begin
      bd = 8'($urandom()); bsh = 3'($urandom_range(0, 7)); bop = 2'($urandom_range(0, 3)); btag = 4'(i);
      cyc();
    end
    chk("b_sustained", nb_in - s0, 20);
    drain();
    lat_on = 0;
    for (int i = 0; i < 150; i++) begin
      bv = $urandom_range(0, 3) != 0; bd = 8'($urandom()); bsh = 3'($urandom_range(0, 7));
      bop = 2'($urandom_range(0, 3)); btag = 4'($urandom()); br = $urandom_range(0, 2) != 0;
      cyc();
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
